// File: rtl/float_to_fixed_stream.sv
// float32 -> signed fixed-point quantizer, 3-stage pipeline with
// round-half-to-even, saturation and a delay-aligned saturation counter.
module float_to_fixed_stream #(
  parameter int DATA_W  = 32,
  parameter int OUT_W   = 32,
  parameter int FRAC_W  = 6,
  parameter int DELAY_W = 7,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               running,
  input  logic [DATA_W-1:0]  in0,
  input  logic [FRAC_W-1:0]  fracBits,
  input  logic [DELAY_W-1:0] delay0,
  output logic [OUT_W-1:0]   out0,
  output logic [CNT_W-1:0]   satCount
);

  localparam int MW = OUT_W + 1;
  localparam int SW = 10;

  localparam logic [OUT_W-1:0] MAX_POS =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG =
    {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [MW-1:0] LIM_P = MW'(MAX_POS);
  localparam logic [MW-1:0] LIM_N = MW'(MIN_NEG);

  typedef enum logic [1:0] {
    CL_ZERO = 2'd0,
    CL_NORM = 2'd1,
    CL_INF  = 2'd2,
    CL_NAN  = 2'd3
  } cls_e;

  typedef struct packed {
    logic                 vld;
    logic                 sgn;
    cls_e                 cls;
    logic [23:0]          sig;
    logic signed [SW-1:0] sh;
  } s1_t;

  typedef struct packed {
    logic          vld;
    logic          sgn;
    cls_e          cls;
    logic [MW-1:0] mag;
    logic          ovf;
  } s2_t;

  logic [DELAY_W-1:0] dly_q, dly_d;
  logic               valid0;
  s1_t                s1_q, s1_d;
  s2_t                s2_q, s2_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               sat3;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign out0     = out_q;
  assign satCount = cnt_q;

  // samples only count once the start delay has fully elapsed
  always_comb begin
    dly_d = dly_q;
    if (run) begin
      dly_d = delay0;
    end else if (running && dly_q != '0) begin
      dly_d = dly_q - 1'b1;
    end
  end

  assign valid0 = (dly_q == '0) && !run;

  logic [7:0]  f_exp;
  logic [22:0] f_man;

  always_comb begin
    f_exp     = in0[30:23];
    f_man     = in0[22:0];
    s1_d      = '0;
    s1_d.vld  = valid0;
    s1_d.sgn  = in0[31];
    s1_d.cls  = CL_NORM;
    s1_d.sig  = {1'b1, f_man};
    s1_d.sh   = SW'(f_exp) - SW'(150)
              + SW'(fracBits);
    if (f_exp == 8'd0) begin
      s1_d.cls = CL_ZERO;
      s1_d.sig = '0;
    end else if (f_exp == 8'hFF) begin
      s1_d.cls = (f_man == '0) ? CL_INF : CL_NAN;
    end
  end

  logic [63:0] wide;
  logic [63:0] rnd;
  logic [25:0] sig_x;
  logic [25:0] trunc;
  logic [25:0] mask;
  logic [4:0]  nsh;
  logic        guard;
  logic        sticky;

  always_comb begin
    s2_d     = '0;
    s2_d.vld = s1_q.vld;
    s2_d.sgn = s1_q.sgn;
    s2_d.cls = s1_q.cls;
    wide     = '0;
    rnd      = '0;
    sig_x    = 26'(s1_q.sig);
    trunc    = '0;
    mask     = '0;
    nsh      = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    if (!s1_q.sh[SW-1]) begin
      if (s1_q.sh > $signed(SW'(OUT_W))) begin
        s2_d.ovf = 1'b1;
      end else begin
        wide     = 64'(s1_q.sig) << s1_q.sh[5:0];
        s2_d.ovf = |wide[63:OUT_W];
        s2_d.mag = wide[MW-1:0];
      end
    end else if (s1_q.sh >= -10'sd25) begin
      // shifted-out bits drive half-to-even rounding
      nsh      = 5'(-s1_q.sh);
      trunc    = sig_x >> nsh;
      guard    = sig_x[nsh - 5'd1];
      mask     = (26'd1 << (nsh - 5'd1)) - 26'd1;
      sticky   = |(sig_x & mask);
      rnd      = 64'(trunc)
               + 64'(guard & (sticky | trunc[0]));
      s2_d.ovf = |rnd[63:OUT_W];
      s2_d.mag = rnd[MW-1:0];
    end
  end

  always_comb begin
    out_d = '0;
    sat3  = 1'b0;
    unique case (1'b1)
      (s2_q.cls == CL_ZERO): begin
        out_d = '0;
      end
      (s2_q.cls == CL_NAN): begin
        out_d = '0;
        sat3  = 1'b1;
      end
      (s2_q.cls == CL_INF): begin
        out_d = s2_q.sgn ? MIN_NEG : MAX_POS;
        sat3  = 1'b1;
      end
      (s2_q.cls == CL_NORM): begin
        if (s2_q.ovf
            || (s2_q.sgn ? (s2_q.mag > LIM_N)
                         : (s2_q.mag > LIM_P))) begin
          out_d = s2_q.sgn ? MIN_NEG : MAX_POS;
          sat3  = 1'b1;
        end else if (s2_q.sgn) begin
          out_d = OUT_W'(-s2_q.mag);
        end else begin
          out_d = OUT_W'(s2_q.mag);
        end
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (run) begin
      cnt_d = '0;
    end else if (running && s2_q.vld && sat3
                 && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
      cnt_q <= '0;
    end else begin
      dly_q <= dly_d;
      cnt_q <= cnt_d;
      if (running) begin
        s1_q  <= s1_d;
        s2_q  <= s2_d;
        out_q <= out_d;
      end
    end
  end

endmodule

// File: tb/tb_float_to_fixed_stream.sv
// Bench for float_to_fixed_stream: directed and random samples
// checked against a real-arithmetic reference with a latency queue.
module tb_float_to_fixed_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        running;
  logic [31:0] in0;
  logic [5:0]  fracBits;
  logic [6:0]  delay0;
  logic [31:0] out0;
  logic [15:0] satCount;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] o;
    bit          sat;
    bit          vld;
  } ent_t;

  ent_t        pipe[$];
  int          dly_m;
  int          cnt_m;
  logic [31:0] exp_out;

  always #5 clk = ~clk;

  float_to_fixed_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .running  (running),
    .in0      (in0),
    .fracBits (fracBits),
    .delay0   (delay0),
    .out0     (out0),
    .satCount (satCount)
  );

  // exact value of x * 2^f rounded half-to-even, then clamped
  function automatic void quant(input logic [31:0] x,
                                input int f,
                                output logic [31:0] o,
                                output bit sat);
    int          e;
    logic [22:0] m;
    logic [63:0] db;
    real         v, fl, fr, r;
    e = int'(x[30:23]);
    m = x[22:0];
    o = '0;
    sat = 1'b0;
    if (e == 0) return;
    if (e == 255) begin
      sat = 1'b1;
      if (m == '0) o = x[31] ? 32'h80000000 : 32'h7FFFFFFF;
      return;
    end
    db = {1'b0, 11'(e + 896), m, 29'b0};
    v = $bitstoreal(db);
    repeat (f) v = v * 2.0;
    fl = $floor(v);
    fr = v - fl;
    if (fr > 0.5) r = fl + 1.0;
    else if (fr == 0.5 && (fl / 2.0) != $floor(fl / 2.0)) r = fl + 1.0;
    else r = fl;
    if (x[31]) r = -r;
    if (r > 2147483647.0) begin
      o = 32'h7FFFFFFF;
      sat = 1'b1;
    end else if (r < -2147483648.0) begin
      o = 32'h80000000;
      sat = 1'b1;
    end else begin
      o = 32'($rtoi(r));
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z.o = '0;
    z.sat = 1'b0;
    z.vld = 1'b0;
    pipe.delete();
    pipe.push_back(z);
    pipe.push_back(z);
    dly_m = 0;
    cnt_m = 0;
    exp_out = '0;
  endtask

  task automatic step(input logic [31:0] x, input int f,
                      input bit r, input bit rn, input int d);
    ent_t        e;
    logic [31:0] o;
    bit          s;
    in0 = x;
    fracBits = 6'(f);
    run = r;
    running = rn;
    delay0 = 7'(d);
    @(posedge clk);
    if (rn) begin
      quant(x, f, o, s);
      e.o = o;
      e.sat = s;
      e.vld = (dly_m == 0) && !r;
      pipe.push_back(e);
      e = pipe.pop_front();
      exp_out = e.o;
      if (!r && e.vld && e.sat && cnt_m != 65535) cnt_m++;
    end
    if (r) begin
      cnt_m = 0;
      dly_m = d;
    end else if (rn && dly_m > 0) begin
      dly_m--;
    end
    #1;
    chk("out0", out0, exp_out);
    chk("satCount", 32'(satCount), 32'(cnt_m));
  endtask

  task automatic feed3(input string tag, input logic [31:0] x,
                       input int f, input logic [31:0] want);
    step(x, f, 1'b0, 1'b1, 0);
    step(32'h0, f, 1'b0, 1'b1, 0);
    step(32'h0, f, 1'b0, 1'b1, 0);
    chk(tag, out0, want);
  endtask

  initial begin
    logic [31:0] x;
    rst_n = 1'b0;
    run = 1'b0;
    running = 1'b0;
    in0 = '0;
    fracBits = '0;
    delay0 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out0", out0, 32'h0);
    chk("reset_sat", 32'(satCount), 32'h0);
    rst_n = 1'b1;

    step(32'h3F800000, 0, 1'b0, 1'b1, 0);
    chk("lat_edge1", out0, 32'h0);
    step(32'h0, 0, 1'b0, 1'b1, 0);
    chk("lat_edge2", out0, 32'h0);
    step(32'h0, 0, 1'b0, 1'b1, 0);
    chk("lat_edge3", out0, 32'h1);

    feed3("r1p5", 32'h3FC00000, 0, 32'h2);
    feed3("r2p5", 32'h40200000, 0, 32'h2);
    feed3("rm1p5", 32'hBFC00000, 0, 32'hFFFFFFFE);
    feed3("rm0p75", 32'hBF400000, 2, 32'hFFFFFFFD);

    step(32'h0, 0, 1'b1, 1'b1, 0);
    feed3("sat_p", 32'h4F000000, 0, 32'h7FFFFFFF);
    chk("sat_p_cnt", 32'(satCount), 32'd1);
    feed3("min_neg", 32'hCF000000, 0, 32'h80000000);
    chk("min_neg_cnt", 32'(satCount), 32'd1);
    feed3("nan", 32'h7FC00000, 0, 32'h0);
    chk("nan_cnt", 32'(satCount), 32'd2);
    feed3("ninf", 32'hFF800000, 0, 32'h80000000);
    chk("ninf_cnt", 32'(satCount), 32'd3);

    feed3("denorm", 32'h00400000, 0, 32'h0);
    feed3("tiny", 32'h33000000, 0, 32'h0);
    feed3("ulp_f24", 32'h3F800001, 24, 32'h01000002);

    step(32'h0, 0, 1'b1, 1'b1, 4);
    for (int i = 0; i < 16; i++)
      step(32'h4F000000, 0, 1'b0, (i % 2) == 0, 0);
    for (int i = 0; i < 3; i++)
      step(32'h0, 0, 1'b0, 1'b1, 0);
    chk("delay_cnt", 32'(satCount), 32'd4);

    step(32'h4F000000, 0, 1'b0, 1'b1, 0);
    step(32'h0, 0, 1'b0, 1'b1, 0);
    step(32'h0, 0, 1'b1, 1'b1, 0);
    chk("run_prio_out", out0, 32'h7FFFFFFF);
    chk("run_prio_cnt", 32'(satCount), 32'd0);

    for (int i = 0; i < 300; i++) begin
      x[31] = 1'($urandom_range(0, 1));
      x[30:23] = 8'($urandom_range(100, 170));
      x[22:0] = 23'($urandom);
      if ($urandom_range(0, 15) == 0) x[30:23] = 8'hFF;
      if ($urandom_range(0, 15) == 0) x[30:23] = 8'h00;
      if ($urandom_range(0, 40) == 0)
        step(x, $urandom_range(0, 31), 1'b1, 1'b1,
             $urandom_range(0, 3));
      else
        step(x, $urandom_range(0, 31), 1'b0,
             $urandom_range(0, 3) != 0, 0);
    end

    step(32'h0, 0, 1'b1, 1'b1, 0);
    feed3("pre_rst", 32'h4F000000, 0, 32'h7FFFFFFF);
    step(32'h3F800000, 0, 1'b0, 1'b1, 0);
    step(32'h40000000, 0, 1'b0, 1'b1, 0);
    rst_n = 1'b0;
    #1;
    chk("async_out0", out0, 32'h0);
    chk("async_sat", 32'(satCount), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step(32'h0, 0, 1'b0, 1'b1, 0);
    chk("post_rst", out0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
